arf_sequencer: RTL and testbench

ARF_SEQUENCER -- requirements
Module: arf_sequencer

---
 rtl/arf_pkg.sv | 118 +++++++++++
 rtl/arf_sequencer.sv | 94 +++++++++
 tb/tb_arf_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/arf_pkg.sv
// Shared opcode, control-field and state encodings for the address register file sequencer,
// plus the Moore output decode used by arf_sequencer.
package arf_pkg;

    typedef enum logic [2:0] {
        OpNop    = 3'b000,
        OpJump   = 3'b001,
        OpPush   = 3'b010,
        OpPop    = 3'b011,
        OpCall   = 3'b100,
        OpRet    = 3'b101,
        OpIncpc  = 3'b110,
        OpClrall = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StExec1,
        StExec2,
        StExec3,
        StWaitMem
    } state_e;

    localparam logic [2:0] FunDec   = 3'b000;
    localparam logic [2:0] FunInc   = 3'b001;
    localparam logic [2:0] FunLoad  = 3'b010;
    localparam logic [2:0] FunClear = 3'b011;

    localparam logic [1:0] SelPc = 2'b00;
    localparam logic [1:0] SelAr = 2'b10;
    localparam logic [1:0] SelSp = 2'b11;

    // Active-low register enables, {PC,AR,SP}.
    localparam logic [2:0] RegNone = 3'b111;
    localparam logic [2:0] RegPc   = 3'b011;
    localparam logic [2:0] RegAr   = 3'b101;
    localparam logic [2:0] RegSp   = 3'b110;
    localparam logic [2:0] RegAll  = 3'b000;

    typedef struct packed {
        logic       cmd_ready;
        logic       done;
        logic [2:0] reg_sel;
        logic [2:0] fun_sel;
        logic [1:0] outc_sel;
        logic [1:0] outd_sel;
        logic       isrc;
        logic       mem_write;
        logic       mem_read;
    } ctrl_t;

    localparam ctrl_t CtrlIdle = '{
        cmd_ready: 1'b1,
        done:      1'b0,
        reg_sel:   RegNone,
        fun_sel:   FunDec,
        outc_sel:  SelPc,
        outd_sel:  SelPc,
        isrc:      1'b0,
        mem_write: 1'b0,
        mem_read:  1'b0
    };

    function automatic ctrl_t decode(state_e st, op_e op);
        ctrl_t c;
        c           = CtrlIdle;
        c.cmd_ready = (st == StIdle);
        case (st)
            StExec1: begin
                case (op)
                    OpNop:    c.done = 1'b1;
                    OpJump:   begin c.reg_sel = RegPc;  c.fun_sel = FunLoad;  c.done = 1'b1; end
                    OpIncpc:  begin c.reg_sel = RegPc;  c.fun_sel = FunInc;   c.done = 1'b1; end
                    OpClrall: begin c.reg_sel = RegAll; c.fun_sel = FunClear; c.done = 1'b1; end
                    OpPush, OpCall: begin c.reg_sel = RegSp; c.fun_sel = FunDec; end
                    OpPop, OpRet:   begin c.outd_sel = SelSp; c.mem_read = 1'b1; end
                    default: ;
                endcase
            end
            StWaitMem: begin
                c.outd_sel = SelSp;
                c.mem_read = 1'b1;
            end
            StExec2: begin
                case (op)
                    OpPush: begin
                        c.outd_sel  = SelSp;
                        c.outc_sel  = SelAr;
                        c.mem_write = 1'b1;
                        c.done      = 1'b1;
                    end
                    OpCall: begin
                        c.outd_sel  = SelSp;
                        c.outc_sel  = SelPc;
                        c.mem_write = 1'b1;
                    end
                    OpPop, OpRet: begin
                        c.reg_sel  = (op == OpPop) ? RegAr : RegPc;
                        c.fun_sel  = FunLoad;
                        c.isrc     = 1'b1;
                        c.outd_sel = SelSp;
                    end
                    default: ;
                endcase
            end
            StExec3: begin
                case (op)
                    OpPop, OpRet: begin c.reg_sel = RegSp; c.fun_sel = FunInc;  c.done = 1'b1; end
                    OpCall:       begin c.reg_sel = RegPc; c.fun_sel = FunLoad; c.done = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/arf_sequencer.sv
// Command sequencer for the PC/AR/SP register file: turns one opcode into a short
// sequence of register-function and memory strobes, with registered Moore outputs.
module arf_sequencer #(
    parameter int unsigned OP_W    = 3,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            CmdValid,
    input  logic [OP_W-1:0] CmdOp,
    output logic            CmdReady,
    output logic            Done,
    output logic [2:0]      RegSel,
    output logic [2:0]      FunSel,
    output logic [1:0]      OutCSel,
    output logic [1:0]      OutDSel,
    output logic            ISrc,
    output logic            MemWrite,
    output logic            MemRead
);
    import arf_pkg::*;

    // Extra WAITMEM cycles beyond the first read cycle spent in EXEC1.
    localparam logic [1:0] WaitInit = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;

    state_e     state_q, state_d;
    op_e        op_q, op_d;
    logic [1:0] wait_q, wait_d;
    ctrl_t      ctrl_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wait_d  = wait_q;
        unique case (state_q)
            StIdle: begin
                if (CmdValid) begin
                    state_d = StExec1;
                    op_d    = op_e'(CmdOp[2:0]);
                end
            end
            StExec1: begin
                case (op_q)
                    OpPush, OpCall: state_d = StExec2;
                    OpPop, OpRet: begin
                        if (MEM_LAT > 1) begin
                            state_d = StWaitMem;
                            wait_d  = WaitInit;
                        end else begin
                            state_d = StExec2;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
            StWaitMem: begin
                if (wait_q == 2'd0) begin
                    state_d = StExec2;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            StExec2: state_d = (op_q == OpPush) ? StIdle : StExec3;
            StExec3: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q after the edge.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIdle;
            op_q    <= OpNop;
            wait_q  <= 2'd0;
            ctrl_q  <= CtrlIdle;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            ctrl_q  <= decode(state_d, op_d);
        end
    end

    assign CmdReady = ctrl_q.cmd_ready;
    assign Done     = ctrl_q.done;
    assign RegSel   = ctrl_q.reg_sel;
    assign FunSel   = ctrl_q.fun_sel;
    assign OutCSel  = ctrl_q.outc_sel;
    assign OutDSel  = ctrl_q.outd_sel;
    assign ISrc     = ctrl_q.isrc;
    assign MemWrite = ctrl_q.mem_write;
    assign MemRead  = ctrl_q.mem_read;

endmodule

// File: tb/tb_arf_sequencer.sv
// Directed bench: drives arf_sequencer against a small PC/AR/SP + memory model and
// checks latencies, strobes and resulting register/memory contents.
module tb_arf_sequencer;

    localparam logic [2:0] NOP = 3'b000, JUMP = 3'b001, PUSH = 3'b010, POP = 3'b011;
    localparam logic [2:0] CALL = 3'b100, RET = 3'b101, INCPC = 3'b110, CLRALL = 3'b111;

    logic       clk, rst_n;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic       cmd_ready, done, isrc, mem_write, mem_read;
    logic [2:0] reg_sel, fun_sel;
    logic [1:0] outc_sel, outd_sel;

    // Second instance, MEM_LAT=1, exercised only for the no-wait read path.
    logic       cmd_valid1;
    logic [2:0] cmd_op1;
    logic       cmd_ready1, done1, isrc1, mem_write1, mem_read1;
    logic [2:0] reg_sel1, fun_sel1;
    logic [1:0] outc_sel1, outd_sel1;

    int n_tests = 0;
    int n_fail  = 0;
    int viol    = 0;

    arf_sequencer #(.OP_W(3), .MEM_LAT(2)) u_dut (
        .Clock(clk), .Reset(rst_n), .CmdValid(cmd_valid), .CmdOp(cmd_op),
        .CmdReady(cmd_ready), .Done(done), .RegSel(reg_sel), .FunSel(fun_sel),
        .OutCSel(outc_sel), .OutDSel(outd_sel), .ISrc(isrc),
        .MemWrite(mem_write), .MemRead(mem_read)
    );

    arf_sequencer #(.OP_W(3), .MEM_LAT(1)) u_dut1 (
        .Clock(clk), .Reset(rst_n), .CmdValid(cmd_valid1), .CmdOp(cmd_op1),
        .CmdReady(cmd_ready1), .Done(done1), .RegSel(reg_sel1), .FunSel(fun_sel1),
        .OutCSel(outc_sel1), .OutDSel(outd_sel1), .ISrc(isrc1),
        .MemWrite(mem_write1), .MemRead(mem_read1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file and memory model driven by the sequencer's strobes.
    logic [15:0] pc, ar, sp, imm;
    logic [15:0] mem [0:511];
    logic        preset_en;
    logic [15:0] preset_pc, preset_ar, preset_sp;

    function automatic logic [15:0] sel_val(input logic [1:0] s);
        case (s)
            2'b00:   return pc;
            2'b10:   return ar;
            2'b11:   return sp;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] arf_fun(input logic [2:0] f, input logic [15:0] cur,
                                            input logic [15:0] src);
        case (f)
            3'b000:  return cur - 16'd1;
            3'b001:  return cur + 16'd1;
            3'b010:  return src;
            3'b011:  return 16'h0000;
            default: return cur;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [15:0] addr, src;
        if (preset_en) begin
            pc <= preset_pc;
            ar <= preset_ar;
            sp <= preset_sp;
        end else begin
            addr = sel_val(outd_sel);
            src  = isrc ? mem[addr[8:0]] : imm;
            if (!reg_sel[2]) pc <= arf_fun(fun_sel, pc, src);
            if (!reg_sel[1]) ar <= arf_fun(fun_sel, ar, src);
            if (!reg_sel[0]) sp <= arf_fun(fun_sel, sp, src);
            if (mem_write) mem[addr[8:0]] <= sel_val(outc_sel);
        end
    end

    // Strobe exclusivity and single-enable rules, watched every cycle.
    always @(negedge clk) begin
        if (mem_write && mem_read) viol++;
        if (reg_sel != 3'b000 && $countones(~reg_sel) > 1) viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preset(input logic [15:0] p, input logic [15:0] a, input logic [15:0] s);
        preset_pc = p;
        preset_ar = a;
        preset_sp = s;
        preset_en = 1'b1;
        tick();
        preset_en = 1'b0;
    endtask

    // Issues one command, injects busy-time noise on CmdValid/CmdOp, returns the Done
    // latency in cycles from acceptance, the number of MemRead cycles and the EXEC1 RegSel.
    task automatic run_cmd(input logic [2:0] op, input string tag, output int cycles,
                           output int reads, output logic [2:0] first_rs);
        cmd_valid = 1'b1;
        cmd_op    = op;
        tick();
        cycles    = 1;
        reads     = 0;
        first_rs  = reg_sel;
        check({tag, "_busy_ready"}, 32'(cmd_ready), 32'd0);
        cmd_op    = ~op;
        while (!done && cycles < 20) begin
            if (mem_read) reads++;
            tick();
            cycles++;
        end
        if (mem_read) reads++;
        cmd_valid = 1'b0;
        tick();
        check({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
    endtask

    int         cyc, rds;
    logic [2:0] rs0;
    logic [7:0] pat;

    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = NOP;
        cmd_valid1 = 1'b0;
        cmd_op1    = NOP;
        imm        = 16'h0000;
        preset_en  = 1'b0;
        preset_pc  = '0;
        preset_ar  = '0;
        preset_sp  = '0;
        repeat (2) tick();
        check("rst_regsel", 32'(reg_sel), 32'h7);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_strobes", {29'd0, done, mem_write, mem_read}, 32'd0);
        check("rst_funsel", 32'(fun_sel), 32'd0);
        rst_n = 1'b1;

        // First command right after reset release.
        run_cmd(NOP, "nop", cyc, rds, rs0);
        check("nop_latency", 32'(cyc), 32'd1);
        check("nop_regsel", 32'(rs0), 32'h7);

        preset(16'h0010, 16'h1234, 16'h0100);
        run_cmd(PUSH, "push", cyc, rds, rs0);
        check("push_latency", 32'(cyc), 32'd2);
        check("push_sp", 32'(sp), 32'h00FF);
        check("push_mem", 32'(mem[9'h0FF]), 32'h1234);

        preset(16'h0010, 16'h1234, 16'h0100);
        imm = 16'h0040;
        run_cmd(CALL, "call", cyc, rds, rs0);
        check("call_latency", 32'(cyc), 32'd3);
        check("call_mem", 32'(mem[9'h0FF]), 32'h0010);
        check("call_pc", 32'(pc), 32'h0040);
        check("call_sp", 32'(sp), 32'h00FF);

        imm = 16'hBEEF;
        run_cmd(RET, "ret", cyc, rds, rs0);
        check("ret_latency", 32'(cyc), 32'd4);
        check("ret_reads", 32'(rds), 32'd2);
        check("ret_pc", 32'(pc), 32'h0010);
        check("ret_sp", 32'(sp), 32'h0100);

        imm = 16'h1357;
        run_cmd(JUMP, "jump", cyc, rds, rs0);
        check("jump_latency", 32'(cyc), 32'd1);
        check("jump_pc", 32'(pc), 32'h1357);

        preset(16'h0020, 16'h0000, 16'h00FF);
        run_cmd(POP, "pop", cyc, rds, rs0);
        check("pop_latency", 32'(cyc), 32'd4);
        check("pop_ar", 32'(ar), 32'h0010);
        check("pop_sp", 32'(sp), 32'h0100);
        check("pop_pc_kept", 32'(pc), 32'h0020);

        // INCPC held valid: accept, execute, idle, accept ...
        preset(16'h0100, 16'h0000, 16'h0100);
        cmd_valid = 1'b1;
        cmd_op    = INCPC;
        for (int i = 0; i < 8; i++) begin
            pat[i] = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        check("incpc_ready_pattern", 32'(pat), 32'h55);
        check("incpc_pc", 32'(pc), 32'h0104);

        preset(16'hAAAA, 16'h5555, 16'h0F0F);
        run_cmd(CLRALL, "clrall", cyc, rds, rs0);
        check("clrall_latency", 32'(cyc), 32'd1);
        check("clrall_regsel", 32'(rs0), 32'h0);
        check("clrall_regsel_after", 32'(reg_sel), 32'h7);
        check("clrall_regs", {pc, ar | sp}, 32'h0);

        // Reset while CALL sits in EXEC2.
        preset(16'h0010, 16'h0000, 16'h0100);
        imm       = 16'h0040;
        cmd_valid = 1'b1;
        cmd_op    = CALL;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("rstmid_exec2_write", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_regsel", 32'(reg_sel), 32'h7);
        check("rstmid_write", 32'(mem_write), 32'd0);
        check("rstmid_ready", 32'(cmd_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("rstmid_no_resume", {29'd0, done, mem_write, reg_sel != 3'b111}, 32'd0);
        check("rstmid_pc", 32'(pc), 32'h0010);

        // MEM_LAT=1: read completes without a wait state.
        cmd_valid1 = 1'b1;
        cmd_op1    = POP;
        tick();
        cmd_valid1 = 1'b0;
        cyc = 1;
        rds = 0;
        while (!done1 && cyc < 20) begin
            if (mem_read1) rds++;
            tick();
            cyc++;
        end
        check("lat1_pop_latency", 32'(cyc), 32'd3);
        check("lat1_pop_reads", 32'(rds), 32'd1);

        check("strobe_rules", 32'(viol), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
